// File: rtl/mode_counter.sv
// Up/down counter with programmable terminal value, wrap-or-saturate boundary
// behaviour and an enable prescaler. Priority per edge: clear > load > enable.
module mode_counter #(
  parameter int unsigned  W        = 8,
  parameter logic [W-1:0] MAX      = {W{1'b1}},
  parameter bit           SAT      = 1'b0,
  parameter int unsigned  PRESCALE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         at_max,
  output logic         at_min,
  output logic         wrap
);

  localparam int unsigned   PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;
  logic [PW-1:0] pre_next;
  logic [W-1:0]  cnt_next;
  logic          wrap_next;

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    cnt_next  = cnt;
    pre_next  = pre_cnt;
    wrap_next = 1'b0;
    if (clear) begin
      cnt_next = '0;
      pre_next = '0;
    end else if (load) begin
      cnt_next = (load_val > MAX) ? MAX : load_val;
      pre_next = '0;
    end else if (en) begin
      if (pre_cnt != PRE_LAST) begin
        pre_next = pre_cnt + PW'(1);
      end else begin
        // Stepping edge: direction is only sampled here.
        pre_next = '0;
        if (up) begin
          if (cnt != MAX) begin
            cnt_next = cnt + W'(1);
          end else if (!SAT) begin
            cnt_next  = '0;
            wrap_next = 1'b1;
          end
        end else begin
          if (cnt != '0) begin
            cnt_next = cnt - W'(1);
          end else if (!SAT) begin
            cnt_next  = MAX;
            wrap_next = 1'b1;
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      pre_cnt <= '0;
      wrap    <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      pre_cnt <= pre_next;
      wrap    <= wrap_next;
    end
  end

  assign at_max = (cnt == MAX);
  assign at_min = (cnt == '0);

endmodule

// File: tb/tb_mode_counter.sv
// Directed bench for mode_counter: three configurations share one stimulus bus;
// expectations are queued when a step is driven and checked after the edge.
module tb_mode_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, up = 1'b0, clear = 1'b0, load = 1'b0;
  logic [7:0] lv = '0;

  logic [7:0] cnt0;
  logic [3:0] cnt1, cnt2;
  logic       mx0, mn0, wr0, mx1, mn1, wr1, mx2, mn2, wr2;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int    dut;
    string tag;
    int    cnt;
    bit    wrap;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // d0: W=8 defaults (MAX=255, wrap, no prescale)
  mode_counter #(.W(8)) d0 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(lv), .cnt(cnt0), .at_max(mx0), .at_min(mn0), .wrap(wr0));

  // d1: W=4, MAX=9, saturating
  mode_counter #(.W(4), .MAX(4'd9), .SAT(1'b1)) d1 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(lv[3:0]), .cnt(cnt1), .at_max(mx1), .at_min(mn1), .wrap(wr1));

  // d2: W=4, MAX=9, wrapping, PRESCALE=3
  mode_counter #(.W(4), .MAX(4'd9), .SAT(1'b0), .PRESCALE(3)) d2 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(lv[3:0]), .cnt(cnt2), .at_max(mx2), .at_min(mn2), .wrap(wr2));

  function automatic int max_of(input int d);
    return (d == 0) ? 255 : 9;
  endfunction

  task automatic check_front();
    exp_t        x;
    logic [31:0] oc;
    logic        ow, omx, omn;
    bit          emx, emn;
    if (sb.size() == 0) return;
    x = sb.pop_front();
    case (x.dut)
      0:       begin oc = {24'd0, cnt0}; ow = wr0; omx = mx0; omn = mn0; end
      1:       begin oc = {28'd0, cnt1}; ow = wr1; omx = mx1; omn = mn1; end
      default: begin oc = {28'd0, cnt2}; ow = wr2; omx = mx2; omn = mn2; end
    endcase
    emx = (x.cnt == max_of(x.dut));
    emn = (x.cnt == 0);
    compared++;
    assert (oc === 32'(x.cnt) && ow === x.wrap && omx === emx && omn === emn)
    else begin
      mismatched++;
      $error("FAIL %s (d%0d): got cnt=%0d wrap=%b at_max=%b at_min=%b, expected cnt=%0d wrap=%b at_max=%b at_min=%b",
             x.tag, x.dut, oc, ow, omx, omn, x.cnt, x.wrap, emx, emn);
    end
  endtask

  task automatic step(input int d, input bit e, input bit u, input bit c,
                      input bit l, input logic [7:0] v, input int ec,
                      input bit ew, input string tag);
    @(negedge clk);
    en = e; up = u; clear = c; load = l; lv = v;
    sb.push_back('{dut: d, tag: tag, cnt: ec, wrap: ew});
    @(posedge clk);
    #1;
    check_front();
  endtask

  // Asserts reset between edges and checks all three counters at once.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    en = 1'b0; up = 1'b0; clear = 1'b0; load = 1'b0; lv = '0;
    reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) sb.push_back('{dut: d, tag: tag, cnt: 0, wrap: 1'b0});
    for (int d = 0; d < 3; d++) check_front();
    #1;
    reset = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    pulse_reset("reset_state");

    // Full up-count through the wrap, ending at 4
    for (int k = 1; k <= 260; k++) step(0, 1, 1, 0, 0, 8'h00, k % 256, k == 256, "up_run_wrap");

    // Down-wrap from 0, then hold with en low
    pulse_reset("reset_before_down");
    step(0, 1, 0, 0, 0, 8'h00, 255, 1'b1, "down_wrap");
    step(0, 0, 0, 0, 0, 8'h00, 255, 1'b0, "hold_after_wrap");

    // Count to 0x55, asynchronous reset, then resume
    pulse_reset("reset_before_55");
    for (int k = 1; k <= 85; k++) step(0, 1, 1, 0, 0, 8'h00, k, 1'b0, "count_to_55");
    pulse_reset("reset_mid_count");
    step(0, 0, 1, 0, 0, 8'h00, 0, 1'b0, "idle_after_release");
    step(0, 1, 1, 0, 0, 8'h00, 1, 1'b0, "resume_after_reset");
    step(0, 1, 1, 0, 1, 8'hA0, 160, 1'b0, "load_d0");
    step(0, 1, 1, 1, 0, 8'h00, 0, 1'b0, "clear_d0");

    // Saturating counter: stuck at 0 going down, stuck at MAX going up
    pulse_reset("reset_d1");
    for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 0, 8'h00, 0, 1'b0, "sat_low");
    for (int k = 1; k <= 12; k++) step(1, 1, 1, 0, 0, 8'h00, (k < 9) ? k : 9, 1'b0, "sat_high");
    step(1, 0, 0, 0, 0, 8'h00, 9, 1'b0, "sat_hold");
    step(1, 1, 1, 0, 1, 8'h0F, 9, 1'b0, "load_clamp");
    step(1, 1, 1, 1, 1, 8'h0F, 0, 1'b0, "clear_beats_load");
    step(1, 0, 1, 0, 1, 8'h05, 5, 1'b0, "load_5");

    // Prescaled counter: one step every third enabled edge
    pulse_reset("reset_d2");
    step(2, 1, 1, 0, 0, 8'h00, 0, 1'b0, "pre_e1");
    step(2, 1, 1, 0, 0, 8'h00, 0, 1'b0, "pre_e2");
    step(2, 1, 1, 0, 0, 8'h00, 1, 1'b0, "pre_e3");
    step(2, 1, 1, 0, 0, 8'h00, 1, 1'b0, "pre_e4");
    step(2, 1, 1, 0, 0, 8'h00, 1, 1'b0, "pre_e5");
    step(2, 1, 1, 0, 0, 8'h00, 2, 1'b0, "pre_e6");
    step(2, 1, 1, 0, 0, 8'h00, 2, 1'b0, "pre_e7");
    step(2, 1, 1, 0, 0, 8'h00, 2, 1'b0, "pre_e8");
    step(2, 1, 1, 0, 1, 8'h07, 7, 1'b0, "load_restarts_window");
    step(2, 1, 1, 0, 0, 8'h00, 7, 1'b0, "post_load_e1");
    step(2, 1, 0, 0, 0, 8'h00, 7, 1'b0, "dir_flip_e2");
    step(2, 1, 0, 0, 0, 8'h00, 6, 1'b0, "dir_sampled_on_step");

    // Prescaled wrap at MAX=9
    step(2, 0, 1, 0, 1, 8'h09, 9, 1'b0, "load_max");
    step(2, 1, 1, 0, 0, 8'h00, 9, 1'b0, "pre_wrap_e1");
    step(2, 1, 1, 0, 0, 8'h00, 9, 1'b0, "pre_wrap_e2");
    step(2, 1, 1, 0, 0, 8'h00, 0, 1'b1, "pre_wrap_step");
    step(2, 1, 1, 0, 0, 8'h00, 0, 1'b0, "wrap_one_cycle");
    step(2, 1, 1, 0, 0, 8'h00, 0, 1'b0, "pre_before_reset");

    // Reset mid-prescale must discard the partial window
    pulse_reset("reset_mid_prescale");
    step(2, 1, 1, 0, 0, 8'h00, 0, 1'b0, "fresh_window_e1");
    step(2, 1, 1, 0, 0, 8'h00, 0, 1'b0, "fresh_window_e2");
    step(2, 1, 1, 0, 0, 8'h00, 1, 1'b0, "fresh_window_e3");

    // en low holds the prescaler position
    step(2, 1, 1, 0, 0, 8'h00, 1, 1'b0, "hold_pre_e1");
    step(2, 0, 1, 0, 0, 8'h00, 1, 1'b0, "hold_pre_off1");
    step(2, 0, 1, 0, 0, 8'h00, 1, 1'b0, "hold_pre_off2");
    step(2, 1, 1, 0, 0, 8'h00, 1, 1'b0, "hold_pre_e2");
    step(2, 1, 1, 0, 0, 8'h00, 2, 1'b0, "hold_pre_step");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
